// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller: opcode encodings of the
// datapath ALU, issue FSM state encoding, wait-counter width and small opcode
// classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // Width of the mul/div hold counter; MULDIV_LAT must fit (1..15).
  localparam int CNT_W = 4;

  // ALU select encodings (4-bit sel input of the ALU).
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_PASS = 4'd5;
  localparam logic [3:0] ALU_MUL  = 4'd6;
  localparam logic [3:0] ALU_DIV  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Multi-cycle opcodes need the ALU inputs held for MULDIV_LAT cycles.
  function automatic logic is_muldiv(input logic [3:0] sel);
    return (sel == ALU_MUL) || (sel == ALU_DIV);
  endfunction

  // Select values with bit 3 set lie outside the ALU opcode space.
  function automatic logic is_illegal(input logic [3:0] sel);
    return sel[3];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. With both requests active the requester that was
// NOT granted last wins; a single active request is always granted.
// Ports:
//   req        in  2  request vector
//   last_grant in  1  index of the most recently granted requester
//   enable     in  1  grants are only issued while enabled
//   gnt        out 2  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Combinational round-robin grant decode.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      gnt[0] = req[0] & (~req[1] | last_grant);
      gnt[1] = req[1] & (~req[0] | ~last_grant);
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Round-robin scheduler sharing one combinational ALU between two requesters.
// An accepted operation is latched into operand/select registers that drive
// the ALU directly; the result is captured after one cycle (simple ops) or
// after MULDIV_LAT cycles (mul/div) and returned on a valid/ready response
// channel. Illegal opcodes and divide-by-zero bypass the ALU entirely.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid/ready/a/b/sel      requester N operation channel (N = 0, 1)
//   alu_a, alu_b, alu_sel         to the ALU (held stable from op registers)
//   alu_res, alu_flag             from the ALU (flag = result is zero)
//   rsp_valid/ready/id/res/flag/err  response channel
//   busy                          controller not idle
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic             busy
);

  // Counter start value for multi-cycle ops: EXEC lasts MULDIV_LAT cycles.
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MULDIV_LAT - 1);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_op_a, w_op_a_nxt;
  logic [WIDTH-1:0]   r_op_b, w_op_b_nxt;
  logic [3:0]         r_op_sel, w_op_sel_nxt;
  logic               r_op_id, w_op_id_nxt;
  logic               r_last_grant, w_last_grant_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic               r_rsp_id, w_rsp_id_nxt;
  logic [WIDTH-1:0]   r_rsp_res, w_rsp_res_nxt;
  logic               r_rsp_flag, w_rsp_flag_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;

  logic [1:0]         w_gnt;
  logic               w_accept;
  logic               w_in_id;
  logic [WIDTH-1:0]   w_in_a;
  logic [WIDTH-1:0]   w_in_b;
  logic [3:0]         w_in_sel;

  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .enable     (r_state == ST_IDLE),
    .gnt        (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_accept   = w_gnt[0] | w_gnt[1];
  assign w_in_id    = w_gnt[1];
  assign w_in_a     = w_gnt[1] ? req1_a   : req0_a;
  assign w_in_b     = w_gnt[1] ? req1_b   : req0_b;
  assign w_in_sel   = w_gnt[1] ? req1_sel : req0_sel;

  assign alu_a     = r_op_a;
  assign alu_b     = r_op_b;
  assign alu_sel   = r_op_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_res   = r_rsp_res;
  assign rsp_flag  = r_rsp_flag;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);

  // Next-state and next-register decode of the issue FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_op_a_nxt       = r_op_a;
    w_op_b_nxt       = r_op_b;
    w_op_sel_nxt     = r_op_sel;
    w_op_id_nxt      = r_op_id;
    w_last_grant_nxt = r_last_grant;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_id_nxt     = r_rsp_id;
    w_rsp_res_nxt    = r_rsp_res;
    w_rsp_flag_nxt   = r_rsp_flag;
    w_rsp_err_nxt    = r_rsp_err;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_a_nxt       = w_in_a;
          w_op_b_nxt       = w_in_b;
          w_op_sel_nxt     = w_in_sel;
          w_op_id_nxt      = w_in_id;
          w_last_grant_nxt = w_in_id;
          if (is_illegal(w_in_sel)) begin
            // Answered immediately; the ALU output is meaningless here.
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_id_nxt    = w_in_id;
            w_rsp_res_nxt   = {WIDTH{1'b0}};
            w_rsp_flag_nxt  = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else if ((w_in_sel == ALU_DIV) && (w_in_b == {WIDTH{1'b0}})) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_id_nxt    = w_in_id;
            w_rsp_res_nxt   = {WIDTH{1'b1}};
            w_rsp_flag_nxt  = 1'b0;
            w_rsp_err_nxt   = 1'b1;
          end else if (is_muldiv(w_in_sel)) begin
            w_state_nxt = ST_EXEC;
            w_cnt_nxt   = LAT_INIT;
          end else begin
            w_state_nxt = ST_EXEC;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_op_id;
          w_rsp_res_nxt   = alu_res;
          w_rsp_flag_nxt  = alu_flag;
          w_rsp_err_nxt   = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_op_a       <= {WIDTH{1'b0}};
      r_op_b       <= {WIDTH{1'b0}};
      r_op_sel     <= 4'd0;
      r_op_id      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_res    <= {WIDTH{1'b0}};
      r_rsp_flag   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_op_sel     <= w_op_sel_nxt;
      r_op_id      <= w_op_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_rsp_res    <= w_rsp_res_nxt;
      r_rsp_flag   <= w_rsp_flag_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Scoreboard bench: expected responses are computed from the operands when an
// operation is accepted and compared when the response handshake occurs.
// A behavioural ALU closes the loop on alu_a/alu_b/alu_sel.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int W   = 32;
  localparam int LAT = 4;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        flag;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_sel, req1_sel;
  logic [W-1:0]  alu_a, alu_b, alu_res;
  logic [3:0]    alu_sel;
  logic          alu_flag;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err, busy;
  logic [W-1:0]  rsp_res;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          bench_last = 1'b1;
  logic          bench_idle = 1'b1;
  logic          prev_valid = 1'b0;
  int            rise_cyc = 0;
  logic          hold_prev = 1'b0;
  logic          h_id, h_flag, h_err;
  logic [W-1:0]  h_res;

  always #5 clk = ~clk;

  // Behavioural ALU: unsigned slt, low-half multiply, pass returns a.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] sel);
    logic [W-1:0] r;
    case (sel)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a;
      4'd6: r = a * b;
      4'd7: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_res  = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_flag = (alu_res == 32'd0);

  alu_issue_ctrl #(.WIDTH(W), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] sel);
    exp_t e;
    e.id  = id;
    e.acc = cyc;
    if (sel >= 4'd8) begin
      e.res = 32'd0; e.flag = 1'b1; e.err = 1'b1; e.lat = 1;
    end else if (sel == 4'd7 && b == 32'd0) begin
      e.res = 32'hFFFF_FFFF; e.flag = 1'b0; e.err = 1'b1; e.lat = 1;
    end else begin
      e.res  = alu_fn(a, b, sel);
      e.flag = (e.res == 32'd0);
      e.err  = 1'b0;
      e.lat  = (sel >= 4'd6) ? 1 + LAT : 2;
    end
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: grant/busy model, scoreboard push on accept, pop on response.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [1:0] eg;
      exp_t e;
      eg = 2'b00;
      if (bench_idle) begin
        eg[0] = req0_valid & (~req1_valid | bench_last);
        eg[1] = req1_valid & (~req0_valid | ~bench_last);
      end
      check_val("busy", {63'd0, busy}, {63'd0, ~bench_idle});
      if (req0_valid || req1_valid)
        check_val("grant", {62'd0, req1_ready, req0_ready}, {62'd0, eg});
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_sel));
        else            sb.push_back(model(1'b0, req0_a, req0_b, req0_sel));
        bench_last = req1_ready;
        bench_idle = 1'b0;
      end
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (hold_prev) begin
        check_val("hold_valid", {63'd0, rsp_valid}, 64'd1);
        check_val("hold_res", {32'd0, rsp_res}, {32'd0, h_res});
        check_val("hold_fie", {61'd0, rsp_id, rsp_flag, rsp_err}, {61'd0, h_id, h_flag, h_err});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_val("spurious_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
          check_val("rsp_res", {32'd0, rsp_res}, {32'd0, e.res});
          check_val("rsp_flag", {63'd0, rsp_flag}, {63'd0, e.flag});
          check_val("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          check_val("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
        end
        bench_idle = 1'b1;
      end
      hold_prev  = rsp_valid && !rsp_ready;
      h_res = rsp_res; h_id = rsp_id; h_flag = rsp_flag; h_err = rsp_err;
      prev_valid = rsp_valid;
    end
  end

  // Present one operation on requester id and wait for its acceptance.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] sel);
    int n;
    logic rdy;
    n = 0;
    if (id == 0) begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
    do begin
      @(negedge clk);
      rdy = (id == 0) ? req0_ready : req1_ready;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check_val("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (id == 0) begin req0_valid = 1'b0; req0_a = $urandom; req0_sel = 4'($urandom); end
    else         begin req1_valid = 1'b0; req1_a = $urandom; req1_sel = 4'($urandom); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bench_idle) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0 || !bench_idle) check_val("drain_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    bench_last = 1'b1;
    bench_idle = 1'b1;
    prev_valid = 1'b0;
    hold_prev  = 1'b0;
    check_val("rst_outs", {55'd0, rsp_valid, busy, rsp_id, rsp_flag, rsp_err,
                           req0_ready, req1_ready, 2'b00}, 64'd0);
    check_val("rst_alu", {28'd0, alu_sel, alu_a}, 64'd0);
    check_val("rst_aluB_res", {alu_b, rsp_res}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_sel = 4'd0;
    req1_a = '0; req1_b = '0; req1_sel = 4'd0;
    #2;
    do_reset();

    // Simple ADD from requester 0
    issue(0, 32'd5, 32'd7, 4'd0);
    drain();

    // Both requesters contend from reset: 0,1,0,1
    do_reset();
    fork
      begin issue(0, 32'd9, 32'd9, 4'd1); issue(0, 32'hAA, 32'h0F, 4'd2); end
      begin issue(1, 32'hF0, 32'h0F, 4'd3); issue(1, 32'd3, 32'd8, 4'd4); end
    join
    drain();

    // MUL hold window
    issue(1, 32'd3, 32'd4, 4'd6);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check_val("mul_hold", {23'd0, busy, alu_sel, alu_a[15:0], alu_b[15:0]},
                {23'd0, 1'b1, 4'd6, 16'd3, 16'd4});
    end
    drain();

    // Error paths and a legal divide
    issue(0, 32'd100, 32'd0, 4'd7);
    drain();
    issue(0, 32'd1, 32'd2, 4'd9);
    drain();
    issue(1, 32'd100, 32'd7, 4'd7);
    drain();
    issue(0, 32'h1234, 32'd0, 4'd5);
    drain();

    // Backpressure: response held while the other requester waits
    rsp_ready = 1'b0;
    issue(0, 32'd20, 32'd22, 4'd0);
    fork
      issue(1, 32'd10, 32'd3, 4'd1);
      begin repeat (6) @(posedge clk); #1 rsp_ready = 1'b1; end
    join
    drain();

    // Reset in the middle of a MUL
    issue(1, 32'd6, 32'd7, 4'd6);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    fork
      issue(1, 32'd1, 32'd1, 4'd0);
      issue(0, 32'd2, 32'd2, 4'd0);
    join
    drain();

    // Random mix
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(int'($urandom_range(0, 1)), ra, rb, 4'($urandom_range(0, 9)));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Two-requester round-robin scheduler that shares the single combinational ALU (add/sub/and/or/slt/pass/mul/div, 4-bit select) in the MIPS datapath.
- Accepts operations over valid/ready and drives the ALU operand and select inputs from stable registers.
- Holds mul/div operands for a programmable number of cycles before capturing the result.
- Returns result, zero flag, requester id and error through one valid/ready response channel.

Parameters:
- WIDTH, 32: operand/result width.
- MULDIV_LAT, 4: cycles the ALU inputs are held before capture for sel 6/7; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  4  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  to ALU EA/EB.
- alu_sel  out  4  to ALU sel.
- alu_res  in  WIDTH  from ALU res.
- alu_flag  in  1  from ALU flag (1 = result zero).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of the response.
- rsp_res  out  WIDTH  result.
- rsp_flag  out  1  zero flag.
- rsp_err  out  1  illegal opcode or divide by zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, operand and select registers 0, last_grant=1 so requester 0 wins first.
- States: IDLE, EXEC, RESP.
- IDLE, grant rules:
  - Grant is combinational.
  - Only one valid requester: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - reqN_ready=1 only in IDLE and only for the granted requester. Never both ready in one cycle.
- IDLE, on accept (valid and ready): latch a, b, sel and id into op registers; last_grant <= id.
  - sel >= 8: go to RESP with rsp_res=0, rsp_flag=1, rsp_err=1. ALU result is not used.
  - sel==7 and b==0: go to RESP with rsp_res=all ones, rsp_flag=0, rsp_err=1.
  - sel 6/7 otherwise: go to EXEC with cnt=MULDIV_LAT-1.
  - sel 0..5: go to EXEC with cnt=0.
- alu_a, alu_b and alu_sel are driven from the op registers at all times. They are stable from the accept edge through the capture edge.
- EXEC:
  - cnt != 0: decrement cnt.
  - cnt == 0: capture alu_res into rsp_res and alu_flag into rsp_flag; rsp_err=0; go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_res, rsp_flag and rsp_err are held constant while rsp_ready=0.
  - rsp_ready=1: go to IDLE; rsp_valid=0 next cycle.
- Latency, with accept in cycle k:
  - Simple op: rsp_valid in cycle k+2.
  - mul/div: rsp_valid in cycle k+1+MULDIV_LAT.
  - Error cases: rsp_valid in cycle k+1.
- Throughput: a new accept is possible only in IDLE, i.e. the cycle after the response handshake. No overlap.
- Requester held off: reqN_a, reqN_b and reqN_sel may change freely while not ready; nothing is latched.
- Arithmetic: no widening. mul result is the low WIDTH bits. slt is unsigned, as the ALU does.
- Reset mid-operation: the pending op and the undelivered response are discarded; no response is emitted.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4, ALU_PASS=5, ALU_MUL=6, ALU_DIV=7.
  - state encoding IDLE/EXEC/RESP.
  - localparam for the cnt width (4 bits).
- Sub-module rr_arb2: 2-way round-robin grant.
  - Inputs: req[1:0], last_grant, enable.
  - Output: one-hot gnt.

Test Plan:
- Reset, then req0 ADD a=5 b=7, rsp_ready=1: req0_ready in cycle 0; rsp_valid in cycle 2 with id=0, res=12, flag=0, err=0.
- Both valid from reset, req0 SUB 9-9, req1 OR 0xF0|0x0F: req0 served first (res=0, flag=1), then req1 (res=0xFF, id=1); alternation continues over 4 ops.
- req1 MUL 3*4 with MULDIV_LAT=4: alu_sel=6 held for 4 cycles; rsp_valid in cycle 5 with res=12; busy=1 throughout.
- req0 DIV b=0 gives res=0xFFFFFFFF, err=1, rsp_valid in cycle 1; req0 sel=9 gives res=0, flag=1, err=1.
- Backpressure: rsp_ready=0 for 5 cycles during RESP: rsp_* stable, both req ready=0; response delivered once rsp_ready=1.
- Assert rst_n low during EXEC of a MUL: all outputs 0 immediately; no response after release; next req0 accepted first.
